lut4_cfg_readback: RTL

Reads back the LUT4 configuration truth tables currently held in the design and serialises them one bit per cycle for off-chip checking.

---
 rtl/lut4_cfg_readback_pkg.sv | 19 +
 rtl/lut4_cfg_readback_if.sv | 26 ++
 rtl/lut4_cfg_readback_piso.sv | 29 ++
 rtl/lut4_cfg_readback.sv | 110 +++++++++++
 4 files changed

// File: rtl/lut4_cfg_readback_pkg.sv
// Shared definitions for the LUT4 configuration readback block:
// truth-table width, default frame header, FSM state type and frame length.
package lut4_cfg_pkg;

  localparam int LUT_BITS = 16;
  localparam logic [7:0] SYNC_WORD_DEFAULT = 8'hA5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Sync header + payload + one parity bit.
  function automatic int frame_len(input int num_luts);
    return 8 + num_luts * LUT_BITS + 1;
  endfunction

endpackage

// File: rtl/lut4_cfg_readback_if.sv
// Serial readback port. Handshake: a bit transfers on every rising clk edge
// where sdo_valid && sdo_ready; while sdo_valid is high and sdo_ready is low
// the producer holds sdo stable. busy/done are status toward the consumer.
interface lut4_cfg_readback_if;
  logic sdo;
  logic sdo_valid;
  logic sdo_ready;
  logic busy;
  logic done;

  modport master (
    output sdo,
    output sdo_valid,
    input  sdo_ready,
    output busy,
    output done
  );

  modport slave (
    input  sdo,
    input  sdo_valid,
    output sdo_ready,
    input  busy,
    input  done
  );
endinterface

// File: rtl/lut4_cfg_readback_piso.sv
// Parallel-in serial-out register for the sync word + truth-table snapshot.
// Shifts left (MSB out first), zero-filling from the bottom.
module cfg_piso #(
  parameter int WIDTH = 72
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic             i_shift,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_msb
);

  logic [WIDTH-1:0] r_sr;

  // Load takes priority; shift only advances on an accepted bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sr <= '0;
    end else if (i_load) begin
      r_sr <= i_data;
    end else if (i_shift) begin
      r_sr <= {r_sr[WIDTH-2:0], 1'b0};
    end
  end

  assign o_msb = r_sr[WIDTH-1];

endmodule

// File: rtl/lut4_cfg_readback.sv
// LUT4 configuration readback: snapshots the live truth tables on start and
// streams sync word, payload (MSB first) and an even-parity bit one bit per
// accepted handshake.
module lut4_cfg_readback
  import lut4_cfg_pkg::*;
#(
  parameter int         NUM_LUTS  = 4,
  parameter logic [7:0] SYNC_WORD = SYNC_WORD_DEFAULT
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         ena,
  input  logic                         start,
  input  logic [NUM_LUTS*LUT_BITS-1:0] cfg_in,
  lut4_cfg_readback_if.master          bus,
  output state_t                       dbg_state
);

  localparam int FRAME_LEN = frame_len(NUM_LUTS);
  localparam int CNT_W     = $clog2(FRAME_LEN);
  localparam int SR_W      = 8 + NUM_LUTS * LUT_BITS;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_LEN - 1);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_parity;
  logic             r_valid;
  logic             r_busy;
  logic             r_done;

  logic w_start_ok;
  logic w_load;
  logic w_accept;
  logic w_last;
  logic w_shift;
  logic w_msb;

  // A new frame may begin from IDLE or straight out of the DONE cycle.
  assign w_start_ok = (r_state == IDLE) || (r_state == DONE);
  assign w_load     = ena && start && w_start_ok;
  assign w_accept   = ena && bus.sdo_ready && (r_state == SHIFT);
  assign w_last     = (r_cnt == LAST_CNT);
  // The parity bit is not in the shift register, so its acceptance needs no shift.
  assign w_shift    = w_accept && !w_last;

  cfg_piso #(
    .WIDTH (SR_W)
  ) u_piso (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_load  (w_load),
    .i_shift (w_shift),
    .i_data  ({SYNC_WORD, cfg_in}),
    .o_msb   (w_msb)
  );

  // Frame sequencing: snapshot on start, count accepted bits, one-cycle DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_parity <= 1'b0;
      r_valid  <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else if (ena) begin
      case (r_state)
        IDLE, DONE: begin
          r_done <= 1'b0;
          if (start) begin
            r_state  <= SHIFT;
            r_cnt    <= '0;
            r_parity <= ^cfg_in;
            r_valid  <= 1'b1;
            r_busy   <= 1'b1;
          end else begin
            r_state  <= IDLE;
          end
        end
        SHIFT: begin
          if (bus.sdo_ready) begin
            if (w_last) begin
              r_state <= DONE;
              r_valid <= 1'b0;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        default: begin
          r_state <= IDLE;
          r_valid <= 1'b0;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  // Parity replaces the (already exhausted) shift register on the last count.
  assign bus.sdo       = ((r_state == SHIFT) && w_last) ? r_parity : w_msb;
  // A stalled design must not present a transferable bit.
  assign bus.sdo_valid = r_valid && ena;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign dbg_state     = r_state;

endmodule
